// File: rtl/mac_pkg.sv
// Shared constants and the product extension helper for the MAC datapath.
package mac_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned LAT_DEF    = 3;
  localparam int unsigned LAT_MAX    = 8;

  // Widest accumulator the extension helper can serve.
  localparam int unsigned EXT_W_MAX  = 128;
  localparam int unsigned EXT_IDX_W  = $clog2(EXT_W_MAX);

  // Sign- or zero-extend the low prod_w bits of p to the full helper width.
  function automatic logic [EXT_W_MAX-1:0] ext_prod(input logic [EXT_W_MAX-1:0] p,
                                                    input int unsigned         prod_w,
                                                    input logic                is_signed);
    logic                 fill;
    logic [EXT_IDX_W-1:0] msb_idx;
    msb_idx  = EXT_IDX_W'(prod_w - 1);
    fill     = is_signed & p[msb_idx];
    ext_prod = '0;
    for (int unsigned i = 0; i < EXT_W_MAX; i++) begin
      ext_prod[EXT_IDX_W'(i)] = (i < prod_w) ? p[EXT_IDX_W'(i)] : fill;
    end
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// Registered multiplier: an operand capture stage followed by LAT product stages,
// each carrying valid/last sideband. All stages advance together on en.
module mult_pipe
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LAT    = LAT_DEF,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                out_valid,
  output logic                out_last,
  output logic [2*DATA_W-1:0] p
);

  localparam int unsigned PW = 2 * DATA_W;

  logic [DATA_W-1:0] a_q, b_q;
  logic              op_v_q, op_l_q;
  logic [PW-1:0]     a_ext, b_ext, prod;
  logic [PW-1:0]     p_q [LAT];
  logic [LAT-1:0]    v_q, l_q;

  // Low PW bits of the product of the extended operands are exact for both signednesses.
  always_comb begin
    a_ext = SIGNED ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    b_ext = SIGNED ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      op_v_q <= 1'b0;
      op_l_q <= 1'b0;
      for (int i = 0; i < LAT; i++) p_q[i] <= '0;
      v_q    <= '0;
      l_q    <= '0;
    end else if (en) begin
      a_q    <= a;
      b_q    <= b;
      op_v_q <= in_valid;
      op_l_q <= in_last;
      p_q[0] <= prod;
      v_q[0] <= op_v_q;
      l_q[0] <= op_l_q;
      for (int i = 1; i < LAT; i++) begin
        p_q[i] <= p_q[i-1];
        v_q[i] <= v_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  assign p         = p_q[LAT-1];
  assign out_valid = v_q[LAT-1];
  assign out_last  = l_q[LAT-1];

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate with valid/ready handshake, emitting one dot
// product per vector and a sticky overflow flag for that vector.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LAT    = LAT_DEF,
  parameter bit          SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int unsigned PW = 2 * DATA_W;

  logic                 adv;
  logic                 tail_v, tail_l;
  logic [PW-1:0]        tail_p;
  logic [EXT_W_MAX-1:0] ext_full;
  logic [ACC_W-1:0]     addend;
  logic [ACC_W:0]       sum;
  logic                 add_ovf;

  logic [ACC_W-1:0] acc_q, acc_d, data_q, data_d;
  logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d, valid_q, valid_d;

  // A pending result that is not being taken freezes everything upstream.
  assign adv      = !(valid_q && !out_ready);
  assign in_ready = adv;

  mult_pipe #(
    .DATA_W (DATA_W),
    .LAT    (LAT),
    .SIGNED (SIGNED)
  ) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (adv),
    .in_valid  (in_valid && adv),
    .in_last   (in_last),
    .a         (in_a),
    .b         (in_b),
    .out_valid (tail_v),
    .out_last  (tail_l),
    .p         (tail_p)
  );

  always_comb begin
    ext_full = ext_prod(EXT_W_MAX'(tail_p), PW, SIGNED);
    addend   = ext_full[ACC_W-1:0];
    sum      = {1'b0, acc_q} + {1'b0, addend};
    // Signed: operands agree in sign but the result does not.
    add_ovf  = SIGNED ? ((acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                         (sum[ACC_W-1] != acc_q[ACC_W-1]))
                      : sum[ACC_W];
  end

  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    data_d    = data_q;
    out_ovf_d = out_ovf_q;
    valid_d   = valid_q;
    if (adv) begin
      if (valid_q && out_ready) valid_d = 1'b0;
      if (tail_v) begin
        if (!tail_l) begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | add_ovf;
        end else begin
          data_d    = sum[ACC_W-1:0];
          out_ovf_d = ovf_q | add_ovf;
          valid_d   = 1'b1;
          acc_d     = '0;
          ovf_d     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      out_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      out_ovf_q <= out_ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: default, 32-bit signed and 32-bit unsigned builds
// share one stimulus stream and are checked against hand-computed results.
module tb_mac_pipe;

  localparam int unsigned LAT = 3;

  logic        clk, rst_n;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_a, in_b;

  logic        in_ready, out_valid, out_ovf;
  logic [39:0] out_data;
  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [31:0] s_out_data;
  logic        u_in_ready, u_out_valid, u_out_ovf;
  logic [31:0] u_out_data;

  int checks = 0;
  int passed = 0;
  int stall_cnt = 0;

  mac_pipe #(.DATA_W(16), .ACC_W(40), .LAT(LAT), .SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  mac_pipe #(.DATA_W(16), .ACC_W(32), .LAT(LAT), .SIGNED(1'b1)) dut_s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a),
    .in_b(in_b), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_ovf(s_out_ovf)
  );

  mac_pipe #(.DATA_W(16), .ACC_W(32), .LAT(LAT), .SIGNED(1'b0)) dut_u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready), .in_a(in_a),
    .in_b(in_b), .in_last(in_last), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_out_data), .out_ovf(u_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one pair and return 1 ns after the edge that transfers it.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    stall_cnt += n;
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      $fatal(1, "input never accepted");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) cyc = -1;
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
    else passed++;
    checks++; if (out_data !== 40'h0) $display("FAIL reset_data: got %h want 0", out_data);
    else passed++;
    checks++; if (out_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", out_ovf);
    else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_single;
    int cyc;
    out_ready = 1'b1;
    send(16'hFFFE, 16'd15, 1'b1);
    wait_out(cyc);
    checks++; if (cyc != LAT + 1) $display("FAIL single_latency: got %0d want %0d", cyc, LAT + 1);
    else passed++;
    checks++;
    if (out_data !== 40'hFF_FFFF_FFE2) $display("FAIL single_data: got %h want ffffffffe2", out_data);
    else passed++;
    checks++; if (out_ovf !== 1'b0) $display("FAIL single_ovf: got %b want 0", out_ovf);
    else passed++;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_drop: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [39:0] res[$];
    out_ready = 1'b1;
    stall_cnt = 0;
    send(16'd3, 16'd4, 1'b0);
    send(16'd6, 16'd7, 1'b0);
    send(16'd4, 16'd15, 1'b0);
    send(16'd8, 16'd9, 1'b1);
    send(16'd1, 16'd1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (out_valid) res.push_back(out_data);
      @(posedge clk); #1;
    end
    checks++; if (stall_cnt != 0) $display("FAIL b2b_nogap: stalls %0d want 0", stall_cnt);
    else passed++;
    checks++; if (res.size() != 2) $display("FAIL b2b_count: got %0d want 2", res.size());
    else passed++;
    if (res.size() >= 2) begin
      checks++; if (res[0] !== 40'd186) $display("FAIL b2b_first: got %0d want 186", res[0]);
      else passed++;
      checks++; if (res[1] !== 40'd1) $display("FAIL b2b_second: got %0d want 1", res[1]);
      else passed++;
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    out_ready = 1'b0;
    send(16'd3, 16'd4, 1'b0);
    send(16'd6, 16'd7, 1'b0);
    send(16'd4, 16'd15, 1'b0);
    send(16'd8, 16'd9, 1'b1);
    send(16'd2, 16'd5, 1'b0);
    send(16'd3, 16'd3, 1'b1);
    wait_out(cyc);
    checks++; if (cyc < 0) $display("FAIL bp_timeout: no result");
    else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", in_ready);
      else passed++;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid);
      else passed++;
      checks++; if (out_data !== 40'd186) $display("FAIL bp_hold: got %0d want 186", out_data);
      else passed++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    wait_out(cyc);
    checks++; if (out_data !== 40'd19 || cyc < 0)
      $display("FAIL bp_next: got %0d want 19 (wait %0d)", out_data, cyc);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int cyc;
    out_ready = 1'b1;
    send(16'h8000, 16'h8000, 1'b0);
    send(16'h8000, 16'h8000, 1'b1);
    wait_out(cyc);
    checks++;
    if (s_out_data !== 32'h8000_0000) $display("FAIL ovf_s_data: got %h want 80000000", s_out_data);
    else passed++;
    checks++; if (s_out_ovf !== 1'b1) $display("FAIL ovf_s_flag: got %b want 1", s_out_ovf);
    else passed++;
    checks++;
    if (out_data !== 40'h00_8000_0000 || out_ovf !== 1'b0)
      $display("FAIL ovf_wide: got %h/%b want 0080000000/0", out_data, out_ovf);
    else passed++;
    checks++;
    if (u_out_data !== 32'h8000_0000 || u_out_ovf !== 1'b0)
      $display("FAIL ovf_u: got %h/%b want 80000000/0", u_out_data, u_out_ovf);
    else passed++;
    @(posedge clk); #1;
    send(16'd2, 16'd3, 1'b1);
    wait_out(cyc);
    checks++;
    if (s_out_data !== 32'd6 || s_out_ovf !== 1'b0)
      $display("FAIL ovf_clear: got %0d/%b want 6/0", s_out_data, s_out_ovf);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    int cyc;
    out_ready = 1'b1;
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out(cyc);
    checks++;
    if (u_out_data !== 32'hFFFE_0001 || u_out_ovf !== 1'b0)
      $display("FAIL uns_data: got %h/%b want fffe0001/0", u_out_data, u_out_ovf);
    else passed++;
    checks++; if (out_data !== 40'd1) $display("FAIL uns_signed_view: got %h want 1", out_data);
    else passed++;
    @(posedge clk); #1;
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out(cyc);
    checks++;
    if (u_out_data !== 32'hFFFC_0002 || u_out_ovf !== 1'b1)
      $display("FAIL uns_carry: got %h/%b want fffc0002/1", u_out_data, u_out_ovf);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    out_ready = 1'b1;
    send(16'd5, 16'd5, 1'b0);
    send(16'd5, 16'd5, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 40'h0)
      $display("FAIL rst_mid_clear: got %b/%h want 0/0", out_valid, out_data);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(16'd2, 16'd2, 1'b1);
    wait_out(cyc);
    checks++; if (out_data !== 40'd4 || cyc < 0)
      $display("FAIL rst_mid_result: got %0d want 4", out_data);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_overflow;
    test_unsigned;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate unit. It is the successor to the fixed 16x16 MULT core used by the matrix datapath.
- Accepts a stream of operand pairs and accumulates their products. On the pair flagged last, it emits the dot product.
- Adds a valid/ready handshake, selectable signedness, a configurable pipeline depth and overflow reporting.
- Sits between the matrix row/column fetch logic and the result buffer. One instance computes one output element.

Parameters:
- DATA_W, 16, operand width in bits.
- ACC_W, 40, accumulator and result width in bits; must be >= 2*DATA_W.
- LAT, 3, multiplier pipeline stages; legal range 1..8.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_last  in  1  final pair of the current vector.
- out_valid  out  1  result held on out_data.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  accumulated dot product.
- out_ovf  out  1  accumulation overflowed ACC_W during this vector.

Behaviour:
- Reset (asynchronous, active-low):
  - Clears all pipeline valid bits, pipeline last bits, the accumulator and the sticky overflow bit.
  - Outputs: out_valid=0, out_data=0, out_ovf=0. in_ready=1 once rst_n is high.
  - Reset mid-vector discards the partial sum. The first pair accepted after reset starts a new vector.
- Transfer rules:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Global advance: adv = !(out_valid && !out_ready).
  - All pipeline stages and the accumulator update only when adv=1.
  - in_ready = adv (combinational).
- Multiplier pipeline:
  - LAT stages, each carrying product, valid and last.
  - Product width is 2*DATA_W, sign- or zero-extended per SIGNED.
- Accumulate stage, when the product at the pipeline tail is valid and adv=1:
  - Not last: acc <= acc + ext(product); ovf_sticky |= overflow of that add.
  - Last: out_data <= acc + ext(product); out_ovf <= ovf_sticky | overflow of that add; out_valid <= 1; acc <= 0; ovf_sticky <= 0.
- Overflow detection:
  - Signed: carry-in to MSB differs from carry-out.
  - Unsigned: carry-out of bit ACC_W-1.
  - Result always wraps modulo 2^ACC_W; there is no saturation.
- Output register behaviour:
  - When out_valid && out_ready and no new last result arrives that cycle: out_valid <= 0; out_data and out_ovf hold their values.
  - When a result is consumed and a new last result arrives in the same cycle, the new result loads; out_valid stays 1.
- Latency: with no stall, a last pair accepted at edge t gives out_valid=1 after edge t+LAT+1. Throughput is one pair per cycle.
- Stall: out_valid=1 with out_ready=0 freezes the entire pipeline and the accumulator. No data is lost or duplicated.
- Single-pair vector (in_last on the first pair): result = that product.
- A vector may be of any length >= 1. Vectors may be back-to-back with no gap cycle.

Decomposition:
- Package mac_pkg:
  - Default constants DATA_W_DEF=16, ACC_W_DEF=40, LAT_DEF=3.
  - LAT_MAX=8.
  - A function for sign/zero extension to ACC_W.
- Sub-module mult_pipe:
  - Parameters DATA_W, LAT, SIGNED.
  - Ports clk, rst_n, en, in_valid, in_last, a, b, out_valid, out_last, p.
  - Holds the LAT-stage registered multiplier with its valid/last sideband.
- mac_pipe holds the handshake, the accumulator, the overflow tracking and the output register.

Test Plan:
- Single pair, defaults: A=-2, B=15, last=1, out_ready=1 -> out_data=-30 (sign-extended to 40 bits), out_ovf=0, out_valid rises LAT+1 cycles after acceptance.
- Four-pair vector, back-to-back: (3,4),(6,7),(4,15),(8,9), last on the 4th -> exactly one result, out_data=186. Immediately follow with vector (1,1) last -> 1 with no gap cycle.
- Backpressure: hold out_ready=0 for 5 cycles while a result is pending -> in_ready=0; out_data stays 186; the following vector still yields the correct sum once out_ready=1.
- Overflow, ACC_W=32, SIGNED=1: (-32768,-32768) twice, last on the 2nd -> out_data=0x80000000, out_ovf=1. The next vector (2,3) -> 6, out_ovf=0.
- Unsigned, SIGNED=0, ACC_W=32: (0xFFFF,0xFFFF) last -> out_data=0xFFFE0001, out_ovf=0.
- Reset mid-vector: accept (5,5),(5,5), assert rst_n=0 for 1 cycle -> out_valid=0, out_data=0. Then (2,2) last -> 4, not 54.
